aes_key_sched_ctrl: RTL and testbench

Iterative, clocked AES key-schedule controller. It accepts a cipher key, expands it one 32-bit word per cycle into an internal round-key buffer, and then serves 128-bit round keys by round index to the cipher round datapath. It replaces the fully combinational key expansion on the encrypt/decrypt path, trading latency for area. It also sequences key loads against round-key reads.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_sched_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and helper functions for the iterative AES key schedule.
//   word_t    : 32-bit key-schedule word
//   state_e   : controller states IDLE / EXPAND / DONE
//   sbox()    : AES forward S-box byte lookup
//   xtime()   : GF(2^8) multiply-by-x, used to step the round constant
//   nr(), nw(): round count and expanded word count for a key of nk words
package aes_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int unsigned nr(input int unsigned nk);
        return nk + 6;
    endfunction

    function automatic int unsigned nw(input int unsigned nk);
        return 4 * (nk + 7);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
//   src : input word
//   sub : S-box substituted word
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t src,
    output word_t sub
);

    assign sub = {sbox(src[31:24]), sbox(src[23:16]), sbox(src[15:8]), sbox(src[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key-schedule controller. Loads an NK-word cipher key, expands it one
// word per cycle into a register buffer, then serves 128-bit round keys by index.
//   clk, rst_n           : clock, asynchronous active-low reset
//   key_valid/key_ready  : key load handshake (ready in IDLE and DONE)
//   key                  : cipher key, word 0 in bits [0:31]
//   busy                 : expansion in progress
//   keys_ready           : round keys available
//   rk_req/rk_round      : round-key request and round index (honoured in DONE only)
//   rk_valid/rk/rk_err   : one-cycle response; rk_err flags rk_round > NR
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [0:32*NK-1] key,
    output logic             busy,
    output logic             keys_ready,
    input  logic             rk_req,
    input  logic [3:0]       rk_round,
    output logic             rk_valid,
    output logic [0:127]     rk,
    output logic             rk_err
);

    localparam int unsigned NR_C = nr(NK);
    localparam int unsigned NW_C = nw(NK);
    localparam int unsigned IW   = $clog2(NW_C);

    state_e        state;
    logic [IW-1:0] i_idx;
    logic [2:0]    j_idx;   // i_idx mod NK, tracked incrementally
    logic [7:0]    rcon;
    word_t         w [NW_C];

    logic          key_xfer;
    word_t         prev_word;
    word_t         old_word;
    word_t         sub_src;
    word_t         sub_res;
    word_t         t_word;
    word_t         new_word;
    logic          round_ok;
    logic [IW-1:0] rd_base;
    logic [0:127]  rd_key;

    assign key_xfer  = key_valid && key_ready;
    assign prev_word = w[i_idx - IW'(1)];
    assign old_word  = w[i_idx - IW'(NK)];

    // One S-box bank shared by the RotWord path (j==0) and the NK=8 mid-key path (j==4).
    always_comb begin
        sub_src = (j_idx == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
        if (j_idx == 3'd0) begin
            t_word = sub_res ^ {rcon, 24'h0};
        end else if (NK == 8 && j_idx == 3'd4) begin
            t_word = sub_res;
        end else begin
            t_word = prev_word;
        end
        new_word = old_word ^ t_word;
    end

    aes_sub_word u_sub_word (
        .src (sub_src),
        .sub (sub_res)
    );

    assign round_ok = (rk_round <= 4'(NR_C));
    assign rd_base  = IW'({rk_round, 2'b00});
    assign rd_key   = {w[rd_base], w[rd_base + IW'(1)], w[rd_base + IW'(2)],
                       w[rd_base + IW'(3)]};

    // Word buffer is intentionally not reset.
    always_ff @(posedge clk) begin
        if (key_xfer) begin
            for (int k = 0; k < int'(NK); k++) begin
                w[k] <= key[32*k +: 32];
            end
        end else if (state == EXPAND) begin
            w[i_idx] <= new_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            i_idx      <= '0;
            j_idx      <= '0;
            rcon       <= RCON_INIT;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            rk_valid   <= 1'b0;
            rk         <= '0;
            rk_err     <= 1'b0;
        end else begin
            rk_valid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    // A key load wins over a coincident read request.
                    if (key_xfer) begin
                        state      <= EXPAND;
                        i_idx      <= IW'(NK);
                        j_idx      <= '0;
                        rcon       <= RCON_INIT;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                    end else if (state == DONE && rk_req) begin
                        rk_valid <= 1'b1;
                        rk_err   <= !round_ok;
                        rk       <= round_ok ? rd_key : '0;
                    end
                end
                EXPAND: begin
                    i_idx <= i_idx + IW'(1);
                    j_idx <= (j_idx == 3'(NK - 1)) ? 3'd0 : j_idx + 3'd1;
                    if (j_idx == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    if (i_idx == IW'(NW_C - 1)) begin
                        state      <= DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed self-checking bench for aes_key_sched_ctrl with NK = 4, 6 and 8 instances.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] K4    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K6    = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K8    =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R4_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R4_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R6_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R8_1  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R8_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R8_14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] KC    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RC_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           key_valid4 = 1'b0, key_ready4, busy4, keys_ready4;
    logic           rk_req4 = 1'b0, rk_valid4, rk_err4;
    logic [3:0]     rk_round4 = '0;
    logic [0:127]   key4 = '0;
    logic [0:127]   rk4;

    logic           key_valid6 = 1'b0, key_ready6, busy6, keys_ready6;
    logic           rk_req6 = 1'b0, rk_valid6, rk_err6;
    logic [3:0]     rk_round6 = '0;
    logic [0:191]   key6 = '0;
    logic [0:127]   rk6;

    logic           key_valid8 = 1'b0, key_ready8, busy8, keys_ready8;
    logic           rk_req8 = 1'b0, rk_valid8, rk_err8;
    logic [3:0]     rk_round8 = '0;
    logic [0:255]   key8 = '0;
    logic [0:127]   rk8;

    int checks = 0;
    int passes = 0;

    aes_key_sched_ctrl #(.NK(4)) u4 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid4), .key_ready(key_ready4),
        .key(key4), .busy(busy4), .keys_ready(keys_ready4), .rk_req(rk_req4),
        .rk_round(rk_round4), .rk_valid(rk_valid4), .rk(rk4), .rk_err(rk_err4)
    );
    aes_key_sched_ctrl #(.NK(6)) u6 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid6), .key_ready(key_ready6),
        .key(key6), .busy(busy6), .keys_ready(keys_ready6), .rk_req(rk_req6),
        .rk_round(rk_round6), .rk_valid(rk_valid6), .rk(rk6), .rk_err(rk_err6)
    );
    aes_key_sched_ctrl #(.NK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid8), .key_ready(key_ready8),
        .key(key8), .busy(busy8), .keys_ready(keys_ready8), .rk_req(rk_req8),
        .rk_round(rk_round8), .rk_valid(rk_valid8), .rk(rk8), .rk_err(rk_err8)
    );

    // Stimulus helpers: all drive and sample on the falling edge.
    task automatic load4(input logic [127:0] k, output int lat);
        key4 = k; key_valid4 = 1'b1;
        @(negedge clk);
        key_valid4 = 1'b0;
        lat = 0;
        while (!keys_ready4 && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic wait4(inout int lat);
        while (!keys_ready4 && lat < 200) begin @(negedge clk); lat++; end
    endtask

    task automatic read4(input logic [3:0] r, output logic v, output logic [127:0] d,
                         output logic e);
        rk_req4 = 1'b1; rk_round4 = r;
        @(negedge clk);
        v = rk_valid4; d = rk4; e = rk_err4;
        rk_req4 = 1'b0;
    endtask

    task automatic read6(input logic [3:0] r, output logic v, output logic [127:0] d,
                         output logic e);
        rk_req6 = 1'b1; rk_round6 = r;
        @(negedge clk);
        v = rk_valid6; d = rk6; e = rk_err6;
        rk_req6 = 1'b0;
    endtask

    task automatic read8(input logic [3:0] r, output logic v, output logic [127:0] d,
                         output logic e);
        rk_req8 = 1'b1; rk_round8 = r;
        @(negedge clk);
        v = rk_valid8; d = rk8; e = rk_err8;
        rk_req8 = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (key_ready4 !== 1'b1) $display("FAIL rst_key_ready got %b want 1", key_ready4); else passes++;
        checks++; if (busy4 !== 1'b0) $display("FAIL rst_busy got %b want 0", busy4); else passes++;
        checks++; if (keys_ready4 !== 1'b0) $display("FAIL rst_keys_ready got %b want 0", keys_ready4); else passes++;
        checks++; if (rk_valid4 !== 1'b0) $display("FAIL rst_rk_valid got %b want 0", rk_valid4); else passes++;
        checks++; if (rk4 !== 128'h0) $display("FAIL rst_rk got %h want 0", rk4); else passes++;
        checks++; if (rk_err4 !== 1'b0) $display("FAIL rst_rk_err got %b want 0", rk_err4); else passes++;
        checks++; if (key_ready6 !== 1'b1 || key_ready8 !== 1'b1)
            $display("FAIL rst_key_ready_nk6_8 got %b%b want 11", key_ready6, key_ready8); else passes++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nk4;
        int lat; logic v, e; logic [127:0] d;
        load4(K4, lat);
        checks++; if (lat !== 40) $display("FAIL nk4_latency got %0d want 40", lat); else passes++;
        read4(4'd0, v, d, e);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== K4)
            $display("FAIL nk4_round0 got v=%b e=%b %h want v=1 e=0 %h", v, e, d, K4); else passes++;
        read4(4'd1, v, d, e);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== R4_1)
            $display("FAIL nk4_round1 got v=%b e=%b %h want v=1 e=0 %h", v, e, d, R4_1); else passes++;
        read4(4'd10, v, d, e);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== R4_10)
            $display("FAIL nk4_round10 got v=%b e=%b %h want v=1 e=0 %h", v, e, d, R4_10); else passes++;
        @(negedge clk);
        checks++; if (rk_valid4 !== 1'b0) $display("FAIL nk4_strobe_one_cycle got %b want 0", rk_valid4); else passes++;
    endtask

    task automatic test_nk6;
        int lat; logic v, e; logic [127:0] d;
        key6 = K6; key_valid6 = 1'b1;
        @(negedge clk);
        key_valid6 = 1'b0;
        checks++; if (busy6 !== 1'b1 || keys_ready6 !== 1'b0)
            $display("FAIL nk6_busy_after_accept got %b/%b want 1/0", busy6, keys_ready6); else passes++;
        lat = 0;
        while (!keys_ready6 && lat < 200) begin @(negedge clk); lat++; end
        checks++; if (lat !== 46) $display("FAIL nk6_latency got %0d want 46", lat); else passes++;
        read6(4'd12, v, d, e);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== R6_12)
            $display("FAIL nk6_round12 got v=%b e=%b %h want v=1 e=0 %h", v, e, d, R6_12); else passes++;
    endtask

    // Also offers a bogus key mid-expansion, which must be ignored.
    task automatic test_nk8;
        int lat; logic v, e; logic [127:0] d;
        key8 = K8; key_valid8 = 1'b1;
        @(negedge clk);
        key_valid8 = 1'b0;
        repeat (5) @(negedge clk);
        key8 = '1; key_valid8 = 1'b1;
        @(negedge clk);
        checks++; if (key_ready8 !== 1'b0 || busy8 !== 1'b1)
            $display("FAIL nk8_ready_in_expand got %b/%b want 0/1", key_ready8, busy8); else passes++;
        @(negedge clk);
        key_valid8 = 1'b0;
        lat = 7;
        while (!keys_ready8 && lat < 200) begin @(negedge clk); lat++; end
        checks++; if (lat !== 52) $display("FAIL nk8_latency got %0d want 52", lat); else passes++;
        read8(4'd1, v, d, e);
        checks++; if (v !== 1'b1 || d !== R8_1)
            $display("FAIL nk8_round1 got v=%b %h want v=1 %h", v, d, R8_1); else passes++;
        read8(4'd2, v, d, e);
        checks++; if (v !== 1'b1 || d !== R8_2)
            $display("FAIL nk8_round2 got v=%b %h want v=1 %h", v, d, R8_2); else passes++;
        read8(4'd14, v, d, e);
        checks++; if (v !== 1'b1 || e !== 1'b0 || d !== R8_14)
            $display("FAIL nk8_round14 got v=%b e=%b %h want v=1 e=0 %h", v, e, d, R8_14); else passes++;
    endtask

    task automatic test_out_of_range;
        int lat; logic v, e; logic [127:0] d; logic seen;
        read4(4'd11, v, d, e);
        checks++; if (v !== 1'b1 || e !== 1'b1 || d !== 128'h0)
            $display("FAIL oor_round11 got v=%b e=%b %h want v=1 e=1 0", v, e, d); else passes++;
        key4 = K4; key_valid4 = 1'b1;
        @(negedge clk);
        key_valid4 = 1'b0;
        rk_req4 = 1'b1; rk_round4 = 4'd1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rk_valid4 !== 1'b0) seen = 1'b1;
        end
        rk_req4 = 1'b0;
        checks++; if (seen !== 1'b0) $display("FAIL req_in_expand got rk_valid=1 want 0"); else passes++;
        lat = 10;
        wait4(lat);
        checks++; if (lat !== 40) $display("FAIL req_in_expand_latency got %0d want 40", lat); else passes++;
    endtask

    task automatic test_reset_mid_expand;
        int lat; logic v, e; logic [127:0] d;
        read4(4'd1, v, d, e);
        key4 = K4; key_valid4 = 1'b1;
        @(negedge clk);
        key_valid4 = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (busy4 !== 1'b1) $display("FAIL mid_busy got %b want 1", busy4); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (key_ready4 !== 1'b1 || busy4 !== 1'b0 || keys_ready4 !== 1'b0)
            $display("FAIL mid_rst_flags got kr=%b b=%b krs=%b want 1/0/0", key_ready4, busy4,
                     keys_ready4); else passes++;
        checks++; if (rk_valid4 !== 1'b0 || rk_err4 !== 1'b0 || rk4 !== 128'h0)
            $display("FAIL mid_rst_rk got v=%b e=%b %h want 0/0/0", rk_valid4, rk_err4, rk4); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load4(K4, lat);
        checks++; if (lat !== 40) $display("FAIL reload_latency got %0d want 40", lat); else passes++;
        read4(4'd10, v, d, e);
        checks++; if (v !== 1'b1 || d !== R4_10)
            $display("FAIL reload_round10 got v=%b %h want v=1 %h", v, d, R4_10); else passes++;
    endtask

    task automatic test_collision;
        int lat; logic v, e; logic [127:0] d;
        key4 = KC; key_valid4 = 1'b1; rk_req4 = 1'b1; rk_round4 = 4'd1;
        @(negedge clk);
        key_valid4 = 1'b0; rk_req4 = 1'b0;
        checks++; if (rk_valid4 !== 1'b0 || busy4 !== 1'b1 || keys_ready4 !== 1'b0)
            $display("FAIL collide_state got v=%b b=%b krs=%b want 0/1/0", rk_valid4, busy4,
                     keys_ready4); else passes++;
        lat = 0;
        wait4(lat);
        checks++; if (lat !== 40) $display("FAIL collide_latency got %0d want 40", lat); else passes++;
        read4(4'd0, v, d, e);
        checks++; if (v !== 1'b1 || d !== KC)
            $display("FAIL collide_round0 got v=%b %h want v=1 %h", v, d, KC); else passes++;
    endtask

    task automatic test_back_to_back;
        rk_req4 = 1'b1; rk_round4 = 4'd11;
        @(negedge clk);
        checks++; if (rk_valid4 !== 1'b1 || rk_err4 !== 1'b1 || rk4 !== 128'h0)
            $display("FAIL b2b_r11 got v=%b e=%b %h want 1/1/0", rk_valid4, rk_err4, rk4); else passes++;
        rk_round4 = 4'd0;
        @(negedge clk);
        checks++; if (rk_valid4 !== 1'b1 || rk_err4 !== 1'b0 || rk4 !== KC)
            $display("FAIL b2b_r0 got v=%b e=%b %h want 1/0 %h", rk_valid4, rk_err4, rk4, KC); else passes++;
        rk_round4 = 4'd10;
        @(negedge clk);
        checks++; if (rk_valid4 !== 1'b1 || rk_err4 !== 1'b0 || rk4 !== RC_10)
            $display("FAIL b2b_r10 got v=%b e=%b %h want 1/0 %h", rk_valid4, rk_err4, rk4, RC_10); else passes++;
        rk_req4 = 1'b0;
        @(negedge clk);
        checks++; if (rk_valid4 !== 1'b0 || rk4 !== RC_10)
            $display("FAIL b2b_hold got v=%b %h want 0 %h", rk_valid4, rk4, RC_10); else passes++;
    endtask

    initial begin
        test_reset();
        test_nk4();
        test_nk6();
        test_nk8();
        test_out_of_range();
        test_reset_mid_expand();
        test_collision();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
